// File: rtl/nios2_mul_seq_if.sv
// Request/response handshake bundle for the sequential 32x32 multiplier.
// The slave side is the multiplier; the master side issues requests and drains results.
interface nios2_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [4:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;

  modport master (
    output req_valid, req_src1, req_src2, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_src1, req_src2, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );
endinterface

// File: rtl/nios2_mul_seq.sv
// Two-pass 32x32 multiply on a 32x16 mult cell of CELL_LATENCY stages.
// MUL_SEQ_SKIP_HI_EN: skip pass 2 when the multiplier's upper half is zero.
module nios2_mul_seq #(
  parameter int CELL_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  nios2_mul_seq_if.slave       bus,
  output logic [31:0]          A_mul_src1,
  output logic [31:0]          A_mul_src2,
  input  logic [31:0]          A_mul_cell_result,
  output logic                 busy
);

  localparam logic [1:0] LAT = 2'(CELL_LATENCY);

  typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_a_src1;
  logic [31:0] r_a_src2;
  logic [15:0] r_src2_hi;
  logic [4:0]  r_tag;
  logic [31:0] r_p1;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic [4:0]  r_rsp_tag;
  logic        r_skip;
  logic        w_req_ready;
  logic        w_accept;
  logic        w_cap1;
  logic        w_cap2;
  logic        w_drain;
  logic        w_wait;

`ifdef MUL_SEQ_SKIP_HI_EN
  always_ff @(posedge clk) begin
    if (reset)         r_skip <= 1'b0;
    else if (w_accept) r_skip <= (bus.req_src2[31:16] == 16'h0);
  end
`else
  assign r_skip = 1'b0;
`endif

  assign w_req_ready    = (r_state == IDLE) && !reset;
  assign w_wait         = (r_state == P1) || (r_state == P2);
  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_tag    = r_rsp_tag;
  assign A_mul_src1     = r_a_src1;
  assign A_mul_src2     = r_a_src2;
  assign busy           = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_cap1   = 1'b0;
    w_cap2   = 1'b0;
    w_drain  = 1'b0;
    unique case (r_state)
      IDLE: if (bus.req_valid && w_req_ready) begin
        w_accept = 1'b1;
        w_next   = P1;
      end
      P1: if (r_cnt == 2'd0) begin
        w_cap1 = 1'b1;
        w_next = r_skip ? DONE : P2;
      end
      P2: if (r_cnt == 2'd0) begin
        w_cap2 = 1'b1;
        w_next = DONE;
      end
      DONE: if (bus.rsp_ready) begin
        w_drain = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 2'd0;
      r_a_src1     <= 32'h0;
      r_a_src2     <= 32'h0;
      r_src2_hi    <= 16'h0;
      r_tag        <= 5'h0;
      r_p1         <= 32'h0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'h0;
      r_rsp_tag    <= 5'h0;
    end else if (w_accept) begin
      r_a_src1  <= bus.req_src1;
      r_a_src2  <= {16'h0, bus.req_src2[15:0]};
      r_src2_hi <= bus.req_src2[31:16];
      r_tag     <= bus.req_tag;
      r_cnt     <= LAT;
    end else if (w_cap1) begin
      r_p1     <= A_mul_cell_result;
      r_a_src2 <= {16'h0, r_src2_hi};
      if (r_skip) begin
        r_rsp_result <= A_mul_cell_result;
        r_rsp_tag    <= r_tag;
        r_rsp_valid  <= 1'b1;
      end else begin
        r_cnt <= LAT;
      end
    end else if (w_cap2) begin
      r_rsp_result <= r_p1 + {A_mul_cell_result[15:0], 16'h0};
      r_rsp_tag    <= r_tag;
      r_rsp_valid  <= 1'b1;
    end else if (w_drain) begin
      r_rsp_valid <= 1'b0;
    end else if (w_wait && r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_nios2_mul_seq.sv
// Directed bench: two multiplier instances (cell latency 1 and 3)
// each driving a behavioural mult cell model.
module tb_nios2_mul_seq;

  logic clk;
  logic reset;

  nios2_mul_seq_if ifa ();
  nios2_mul_seq_if ifb ();

  logic [31:0] a_s1, a_s2, a_res;
  logic [31:0] b_s1, b_s2, b_res;
  logic [31:0] b_p0, b_p1;
  logic        busy_a, busy_b;

  int n_tot = 0;
  int n_bad = 0;

  nios2_mul_seq #(.CELL_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave),
    .A_mul_src1(a_s1), .A_mul_src2(a_s2),
    .A_mul_cell_result(a_res), .busy(busy_a)
  );

  nios2_mul_seq #(.CELL_LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave),
    .A_mul_src1(b_s1), .A_mul_src2(b_s2),
    .A_mul_cell_result(b_res), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_res <= a_s1 * {16'h0, a_s2[15:0]};
    b_p0  <= b_s1 * {16'h0, b_s2[15:0]};
    b_p1  <= b_p0;
    b_res <= b_p1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [31:0] s2, input int cl);
`ifdef MUL_SEQ_SKIP_HI_EN
    return (s2[31:16] == 16'h0) ? cl + 1 : 2 * (cl + 1);
`else
    return 2 * (cl + 1) + 0 * int'(s2[0]);
`endif
  endfunction

  task automatic run_a(input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] tg, input logic [31:0] exp);
    int k;
    ifa.req_src1  = s1;
    ifa.req_src2  = s2;
    ifa.req_tag   = tg;
    ifa.req_valid = 1'b1;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    chk("busy", 32'(busy_a), 32'd1);
    k = 0;
    while (!ifa.rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(lat(s2, 1)));
    chk("result", ifa.rsp_result, exp);
    chk("tag", 32'(ifa.rsp_tag), 32'(tg));
    ifa.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifa.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(ifa.rsp_valid), 32'd0);
    chk("ready_back", 32'(ifa.req_ready), 32'd1);
  endtask

  initial begin
    int k;
    clk = 1'b0;
    reset = 1'b1;
    ifa.req_valid = 1'b0; ifa.req_src1 = '0; ifa.req_src2 = '0;
    ifa.req_tag = '0; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_src1 = '0; ifb.req_src2 = '0;
    ifb.req_tag = '0; ifb.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_src1", a_s1, 32'h0);
    chk("rst_src2", a_s2, 32'h0);
    chk("rst_result", ifa.rsp_result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(ifa.req_ready), 32'd1);

    run_a(32'd3, 32'd5, 5'd7, 32'h0000000F);
    run_a(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001);
    run_a(32'h00010000, 32'h00010000, 5'd2, 32'h00000000);
    run_a(32'h12345678, 32'h9ABCDEF0, 5'd31, 32'h242D2080);
    run_a(32'h0000FFFF, 32'h0000FFFF, 5'd9, 32'hFFFE0001);

    // backpressure with a second request pending throughout
    ifa.req_src1 = 32'd6; ifa.req_src2 = 32'h00010002; ifa.req_tag = 5'd4;
    ifa.req_valid = 1'b1;
    @(posedge clk); #1;
    ifa.req_src1 = 32'd100; ifa.req_src2 = 32'd100; ifa.req_tag = 5'd5;
    k = 0;
    while (!ifa.rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", 32'(k), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_result", ifa.rsp_result, 32'h0006000C);
      chk("bp_ready", 32'(ifa.req_ready), 32'd0);
    end
    chk("bp_valid", 32'(ifa.rsp_valid), 32'd1);
    chk("bp_tag", 32'(ifa.rsp_tag), 32'd4);
    ifa.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b0;
    chk("bp_drop", 32'(ifa.rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(ifa.req_ready), 32'd1);

    // reset in P2 discards the operation
    ifa.req_src1 = 32'd9; ifa.req_src2 = 32'h00030004; ifa.req_tag = 5'd3;
    ifa.req_valid = 1'b1;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("mid_rst_src1", a_s1, 32'h0);
    chk("mid_rst_src2", a_s2, 32'h0);
    chk("mid_rst_ready", 32'(ifa.req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready1", 32'(ifa.req_ready), 32'd1);
    ifa.rsp_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ifa.rsp_valid) k++;
    end
    ifa.rsp_ready = 1'b0;
    chk("mid_rst_no_rsp", 32'(k), 32'd0);
    run_a(32'd3, 32'd5, 5'd7, 32'h0000000F);

    // cell latency 3
    ifb.req_src1 = 32'd7; ifb.req_src2 = 32'h00020003; ifb.req_tag = 5'd12;
    ifb.req_valid = 1'b1;
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
    chk("b_src1", b_s1, 32'd7);
    k = 0;
    while (!ifb.rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 3) chk("b_src2_pass1", b_s2, 32'h00000003);
      if (k == 5) chk("b_src2_pass2", b_s2, 32'h00000002);
    end
    chk("b_latency", 32'(k), 32'd8);
    chk("b_result", ifb.rsp_result, 32'h000E0015);
    chk("b_tag", 32'(ifb.rsp_tag), 32'd12);
    @(posedge clk); #1;
    chk("b_drop", 32'(ifb.rsp_valid), 32'd0);
    chk("b_idle", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/nios2_mul_seq.md
NIOS2_MUL_SEQ -- requirements
Module: nios2_mul_seq

Interface
REQ-001 The block SHALL have one parameter, CELL_LATENCY, default 1, meaning the number of register stages in the mult cell between the A_mul_src* inputs and A_mul_cell_result; legal values are 1..3.
REQ-002 Clock and reset: one clock, synchronous active-high reset.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
REQ-003 Request side:
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request.
- req_src1  in  32  multiplicand.
- req_src2  in  32  multiplier.
- req_tag  in  5  destination-register tag.
REQ-004 Mult cell side:
- A_mul_src1  out  32  operand A to the cell.
- A_mul_src2  out  32  operand B to the cell; the cell uses only bits [15:0].
- A_mul_cell_result  in  32  cell result, equal to low32(A_mul_src1 * A_mul_src2[15:0]), valid CELL_LATENCY edges after the operands.
REQ-005 Response side:
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  32  low32(req_src1 * req_src2).
- rsp_tag  out  5  tag of the request.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-006 The FSM SHALL have four states, with these transitions:
- IDLE -> P1 on req_valid && req_ready.
- P1 -> P2 at pass-1 capture.
- P2 -> DONE at pass-2 capture.
- DONE -> IDLE on rsp_valid && rsp_ready.
REQ-007 req_ready SHALL equal (state == IDLE); no request is accepted in any other state.
REQ-008 On accept (edge E0), the block SHALL:
- latch req_src1, req_src2 and req_tag;
- drive A_mul_src1 = req_src1 and A_mul_src2 = {16'h0, req_src2[15:0]};
- load the wait counter with CELL_LATENCY.
REQ-009 In P1 and P2, the wait counter SHALL decrement once per cycle while nonzero; capture occurs on the edge where it is 0, i.e. CELL_LATENCY+1 edges after the operands change.
REQ-010 At pass-1 capture, the block SHALL:
- store P1 = A_mul_cell_result;
- drive A_mul_src1 = latched src1 and A_mul_src2 = {16'h0, latched src2[31:16]};
- reload the counter with CELL_LATENCY.
REQ-011 At pass-2 capture, rsp_result SHALL become P1 + {A_mul_cell_result[15:0], 16'h0}, computed modulo 2^32; rsp_tag SHALL become the latched tag, and rsp_valid SHALL rise.
REQ-012 The A_mul_src* outputs SHALL be held stable during every wait; they change only on accept or at pass-1 capture.
REQ-013 In DONE, rsp_valid SHALL stay high and rsp_result/rsp_tag SHALL stay stable until rsp_ready is sampled high; rsp_valid falls on the following edge.
REQ-014 Request-to-rsp_valid latency SHALL be 2*(CELL_LATENCY+1) cycles, which is 4 at the default.
REQ-015 Result arithmetic SHALL be unsigned and truncated to 32 bits; the same 32-bit result is correct for signed MUL.
REQ-016 req_valid SHALL be ignored outside IDLE.
REQ-017 A held rsp_ready with no rsp_valid SHALL have no effect.

Reset
REQ-018 On reset, the block SHALL force:
- state = IDLE;
- rsp_valid = 0, busy = 0;
- rsp_result, rsp_tag, A_mul_src1, A_mul_src2, P1 and the counter = 0.
REQ-019 A reset asserted in any state, including mid-wait and DONE with rsp_valid high, SHALL abort the operation and discard it with no response.
REQ-020 req_ready SHALL be 0 while reset is high and 1 on the first cycle after reset is released.

Configuration
REQ-021 The macro MUL_SEQ_SKIP_HI_EN SHALL control the pass-2 skip.
- Defined: at accept, if req_src2[31:16] == 0 the FSM goes P1 -> DONE directly, with rsp_result = P1 and latency CELL_LATENCY+1.
- Not defined: both passes always run, and latency is always 2*(CELL_LATENCY+1).
- Results SHALL be identical in both builds.

Verification
REQ-022 Basic multiply: src1=3, src2=5, tag=7 -> rsp_result=0x0000000F, rsp_tag=7, rsp_valid 4 cycles after accept (2 with MUL_SEQ_SKIP_HI_EN).
REQ-023 Full-width operands: src1=0xFFFFFFFF, src2=0xFFFFFFFF -> both passes see 0xFFFF0001; rsp_result=0x00000001.
REQ-024 Truncation: src1=0x00010000, src2=0x00010000 -> rsp_result=0x00000000; src1=0x12345678, src2=0x9ABCDEF0 -> rsp_result=0x242D2080.
REQ-025 Backpressure: rsp_ready low for 10 cycles with req_valid high throughout -> rsp_result stable, req_ready=0, no second accept; one cycle after rsp_ready rises, req_ready=1.
REQ-026 Reset mid-operation: reset pulsed in P2 -> no rsp_valid, busy=0, A_mul_src*=0; a new request then completes normally.
REQ-027 CELL_LATENCY=3, src1=7, src2=0x00020003 -> rsp_result=0x000E0015 after 8 cycles; A_mul_src2 reads 0x00000003 during pass 1 and 0x00000002 during pass 2.
